// File: rtl/norm_shift_ctrl.sv
// rtl/norm_shift_ctrl.sv - load/shift-left normalisation sequencer
// Drives Ldx/shiftL of the operand register until its MSB is set, it is zero, or the cap is hit.
module norm_shift_ctrl #(
   parameter int WIDTH     = 16,
   parameter int MAX_SHIFT = 15,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] engx,
   output logic             Ldx,
   output logic             shiftL,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic             sat,
   output logic [CNT_W-1:0] shift_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVAL,
      SHIFT,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFT);

   state_t           state;
   logic [CNT_W-1:0] cnt_next;

   assign cnt_next = shift_cnt + 1'b1;

   // engx seen during a SHIFT cycle is the pre-shift value, so bit WIDTH-2 is the MSB after this shift
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         Ldx       <= 1'b0;
         shiftL    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         zero      <= 1'b0;
         sat       <= 1'b0;
         shift_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  Ldx       <= 1'b1;
                  busy      <= 1'b1;
                  zero      <= 1'b0;
                  sat       <= 1'b0;
                  shift_cnt <= '0;
               end
            end
            LOAD: begin
               Ldx   <= 1'b0;
               state <= EVAL;
            end
            EVAL: begin
               if (engx == '0) begin
                  zero  <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (engx[WIDTH-1]) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  shiftL <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               shift_cnt <= cnt_next;
               if (engx[WIDTH-2] || (cnt_next == MAX_CNT)) begin
                  sat    <= ~engx[WIDTH-2];
                  shiftL <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Ldx    <= 1'b0;
               shiftL <= 1'b0;
               busy   <= 1'b0;
               done   <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// tb/tb_norm_shift_ctrl.sv - scoreboard bench for norm_shift_ctrl
// Two instances (cap 15 and cap 4), each closed around a model of the shift register.
module tb_norm_shift_ctrl;

   typedef struct {
      logic [15:0] engx;
      logic [4:0]  cnt;
      logic        zero;
      logic        sat;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start  [2];
   logic [15:0] operand[2];
   logic [15:0] regv   [2];
   logic        ldx    [2];
   logic        shl    [2];
   logic        busy   [2];
   logic        done   [2];
   logic        zero   [2];
   logic        sat    [2];
   logic [4:0]  cnt    [2];

   exp_t q[2][$];
   int   tests = 0;
   int   fails = 0;

   norm_shift_ctrl #(.WIDTH(16), .MAX_SHIFT(15), .CNT_W(5)) dut_a (
      .clk(clk), .rst(rst), .start(start[0]), .engx(regv[0]),
      .Ldx(ldx[0]), .shiftL(shl[0]), .busy(busy[0]), .done(done[0]),
      .zero(zero[0]), .sat(sat[0]), .shift_cnt(cnt[0])
   );

   norm_shift_ctrl #(.WIDTH(16), .MAX_SHIFT(4), .CNT_W(5)) dut_b (
      .clk(clk), .rst(rst), .start(start[1]), .engx(regv[1]),
      .Ldx(ldx[1]), .shiftL(shl[1]), .busy(busy[1]), .done(done[1]),
      .zero(zero[1]), .sat(sat[1]), .shift_cnt(cnt[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) regv[i] <= 16'h0000;
         else if (ldx[i]) regv[i] <= operand[i];
         else if (shl[i]) regv[i] <= {regv[i][14:0], 1'b0};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   int   lat_m   [2];
   int   shifts_m[2];
   bit   active_m[2];
   bit   overlap_m[2];
   bit   prev_done[2];
   exp_t e_m;

   // Monitor: pops one expectation per done pulse
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            active_m[i]  = 1'b0;
            overlap_m[i] = 1'b0;
            prev_done[i] = 1'b0;
         end else begin
            if (ldx[i]) begin
               active_m[i]  = 1'b1;
               lat_m[i]     = 0;
               shifts_m[i]  = 0;
               overlap_m[i] = 1'b0;
            end else if (active_m[i]) begin
               lat_m[i]++;
            end
            if (shl[i]) shifts_m[i]++;
            if (ldx[i] && shl[i]) overlap_m[i] = 1'b1;
            if (done[i]) begin
               if (q[i].size() == 0) begin
                  chk("unexpected_done", 32'(i), 32'hFFFF);
               end else begin
                  e_m = q[i].pop_front();
                  chk("shift_cnt", 32'(cnt[i]), 32'(e_m.cnt));
                  chk("zero", 32'(zero[i]), 32'(e_m.zero));
                  chk("sat", 32'(sat[i]), 32'(e_m.sat));
                  chk("engx_final", 32'(regv[i]), 32'(e_m.engx));
                  chk("shiftL_cycles", 32'(shifts_m[i]), 32'(e_m.cnt));
                  chk("latency", 32'(lat_m[i]), 32'(e_m.lat));
                  chk("ldx_shl_overlap", 32'(overlap_m[i]), 32'h0);
                  chk("done_single", 32'(prev_done[i]), 32'h0);
                  chk("busy_at_done", 32'(busy[i]), 32'h1);
               end
               active_m[i] = 1'b0;
            end
            prev_done[i] = done[i];
         end
      end
   end

   task automatic push(input int u, input logic [15:0] fin, input int c, input bit z, input bit s);
      exp_t e;
      e.engx = fin;
      e.cnt  = 5'(c);
      e.zero = z;
      e.sat  = s;
      e.lat  = 2 + c;
      q[u].push_back(e);
   endtask

   task automatic wait_done(input int u);
      int n;
      n = 0;
      while (!done[u] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done[u]) chk("done_timeout", 32'(n), 32'h0);
   endtask

   task automatic run_op(input int u, input logic [15:0] op, input logic [15:0] fin,
                         input int c, input bit z, input bit s);
      push(u, fin, c, z, s);
      operand[u] = op;
      start[u] = 1'b1;
      @(negedge clk);
      start[u] = 1'b0;
      wait_done(u);
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i]   = 1'b0;
         operand[i] = 16'h0000;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ldx", 32'(ldx[i]), 32'h0);
         chk("rst_shiftL", 32'(shl[i]), 32'h0);
         chk("rst_busy", 32'(busy[i]), 32'h0);
         chk("rst_done", 32'(done[i]), 32'h0);
         chk("rst_flags", 32'({zero[i], sat[i]}), 32'h0);
         chk("rst_cnt", 32'(cnt[i]), 32'h0);
      end
      rst = 1'b1;
      @(negedge clk);

      run_op(0, 16'h0001, 16'h8000, 15, 1'b0, 1'b0);
      run_op(0, 16'h0000, 16'h0000, 0, 1'b1, 1'b0);
      run_op(0, 16'h00F0, 16'hF000, 8, 1'b0, 1'b0);
      run_op(0, 16'h8000, 16'h8000, 0, 1'b0, 1'b0);
      run_op(1, 16'h0010, 16'h0100, 4, 1'b0, 1'b1);
      run_op(1, 16'h0800, 16'h8000, 4, 1'b0, 1'b0);
      run_op(1, 16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0);
      run_op(1, 16'h0000, 16'h0000, 0, 1'b1, 1'b0);

      // Reset in the middle of a shift sequence: no expectation is queued for the aborted op
      operand[0] = 16'h0001;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      n = 0;
      for (int k = 0; k < 40 && n < 5; k++) begin
         @(negedge clk);
         if (shl[0]) n++;
      end
      chk("pre_reset_shifts", 32'(n), 32'h5);
      #2 rst = 1'b0;
      #1;
      chk("midrst_shiftL", 32'(shl[0]), 32'h0);
      chk("midrst_busy", 32'(busy[0]), 32'h0);
      chk("midrst_cnt", 32'(cnt[0]), 32'h0);
      chk("midrst_flags", 32'({ldx[0], done[0], zero[0], sat[0]}), 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("inrst_shiftL", 32'(shl[0]), 32'h0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("postrst_shiftL", 32'(shl[0]), 32'h0);
      run_op(0, 16'h8000, 16'h8000, 0, 1'b0, 1'b0);

      // start held high across two operations
      push(0, 16'h8000, 1, 1'b0, 1'b0);
      push(0, 16'h8000, 2, 1'b0, 1'b0);
      operand[0] = 16'h4000;
      start[0] = 1'b1;
      @(negedge clk);
      wait_done(0);
      operand[0] = 16'h2000;
      n = 0;
      for (int k = 0; k < 10 && !ldx[0]; k++) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_restart_gap", 32'(n), 32'h2);
      wait_done(0);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_b2b", 32'(busy[0]), 32'h0);

      chk("queue_a_empty", 32'(q[0].size()), 32'h0);
      chk("queue_b_empty", 32'(q[1].size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/norm_shift_ctrl.md
# norm_shift_ctrl

Sequencer for the 16-bit load/shift-left register (Ldx, shiftL, engx). On a start request it loads the operand, then left-shifts it until the MSB is 1, the value is found to be zero, or a shift cap is reached. It reports the shift count so downstream logic can adjust the exponent. It sits between the top-level control FSM and the shift register and is that register's only driver of Ldx and shiftL.

## Interface
- WIDTH, 16, width of the controlled register and of the engx feedback.
- MAX_SHIFT, 15, maximum number of shifts per operation (1..WIDTH-1).
- CNT_W, 5, width of shift_cnt; must hold MAX_SHIFT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, **active-low**. rst=0 immediately forces reset state. The shift register's active-high reset is driven from ~rst at integration.
- start  in  1  request; sampled only in IDLE.
- engx  in  WIDTH  current register contents (feedback).
- Ldx  out  1  load strobe to the shift register.
- shiftL  out  1  shift-left strobe to the shift register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- zero  out  1  result flag: loaded value was 0.
- sat  out  1  result flag: stopped at MAX_SHIFT with engx[WIDTH-1] still 0.
- shift_cnt  out  CNT_W  number of shifts performed.

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, DONE. All outputs are registered or decoded from state only (Moore); start and engx are never combinationally passed to outputs.
- IDLE: when start=1, clear shift_cnt, zero and sat, and go to LOAD. Otherwise stay.
- LOAD: Ldx=1 for exactly one cycle, then go to EVAL.
- EVAL: engx holds the loaded value.
  - engx==0: set zero=1, go to DONE (shift_cnt=0).
  - engx[WIDTH-1]==1: go to DONE (shift_cnt=0).
  - MAX_SHIFT==0 is illegal and not supported.
  - Otherwise go to SHIFT.
- SHIFT: shiftL=1 every cycle. Each edge increments shift_cnt.
  - Leave to DONE at the edge where engx[WIDTH-2]==1 (the MSB after this shift).
  - Also leave to DONE when shift_cnt+1==MAX_SHIFT. If engx[WIDTH-2]==0 in that case, set sat=1.
- DONE: done=1 for one cycle, then go to IDLE.
- shift_cnt, zero and sat hold their values from DONE until the next accepted start.
- Ldx and shiftL are never high in the same cycle.
- start outside IDLE is ignored; there is no queuing. A start held high through DONE is re-accepted in the following IDLE cycle.
- Reset (rst=0 at any time, including mid-shift): state=IDLE, with Ldx, shiftL, busy, done, zero and sat all 0 and shift_cnt=0. The register contents are undefined to this block; a new start reloads them.

## Timing
- Edge E0 samples start=1. Ldx is high in cycle E0–E1, and the register loads at E1.
- EVAL occupies cycle E1–E2.
- For a nonzero value with z leading zeros (z≥1, z≤MAX_SHIFT), shiftL is high for z cycles, E2..E(2+z). done is high in cycle E(2+z)–E(3+z).
- z=0 or zero value: done is high in cycle E2–E3. Minimum latency is 3 cycles from start to done.
- Saturated case: exactly MAX_SHIFT shift cycles.
- busy rises with the E0 edge and falls at the edge ending DONE.
- The earliest next start accepted is the first IDLE cycle after DONE, so back-to-back operations are spaced z+4 edges apart.

## Test plan
- Reset mid-SHIFT (rst=0 with operand 0x0001 after 5 shifts) → all outputs 0 immediately, state IDLE, no further shiftL. After release, start with 0x8000 → done 3 cycles later, shift_cnt=0.
- Operand 0x0001, MAX_SHIFT=15 → Ldx 1 cycle, shiftL 15 consecutive cycles, engx=0x8000, shift_cnt=15, sat=0, zero=0, done single pulse.
- Operand 0x0000 → no shiftL, zero=1, shift_cnt=0, done at E2.
- Operand 0x00F0 → 8 shift cycles, engx=0xF000, shift_cnt=8.
- MAX_SHIFT=4, operand 0x0010 → 4 shifts, engx=0x0100, sat=1, shift_cnt=4.
- start held high continuously with operands 0x4000 then 0x2000 → start ignored while busy. Second operation begins in the IDLE cycle after the first done; shift_cnt=1, then 2; Ldx and shiftL never overlap.
